// File: rtl/sysid_regfile_if.sv
// Avalon-MM slave bus bundle for the system-identification register file.
// The master drives address/strobes/write data; the slave returns registered read data.
interface sysid_regfile_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regfile.sv
// System-identification slave: build ID/timestamp, prescaled 64-bit uptime counter
// with a coherent high-word snapshot, and a bank of byte-writable scratch registers.
module sysid_regfile #(
  parameter logic [31:0] SYSTEM_ID   = 32'h52415801,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int          PRESCALE    = 1,
  parameter int          NUM_SCRATCH = 4,
  parameter int          ADDR_W      = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  sysid_regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TS     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_UP_LO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_UP_HI  = ADDR_W'(3);
  localparam int                SCR_BASE    = 4;
  localparam logic [15:0]       PRE_LAST    = 16'(PRESCALE - 1);

  logic [63:0] cnt;
  logic [15:0] pre;
  logic [31:0] shadow_hi;
  logic [31:0] scratch [NUM_SCRATCH];

  logic [31:0] read_mux;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wr_accept;
  logic        clear_up;
  logic        snap_hi;
  logic        tick;

  // A simultaneous read wins: the write half of the transfer is discarded.
  assign wr_accept = bus.write && !bus.read;
  assign clear_up  = wr_accept && (bus.address == ADDR_UP_LO);
  assign snap_hi   = bus.read && (bus.address == ADDR_UP_LO);
  assign tick      = (pre == PRE_LAST);

  always_comb begin
    read_mux = '0;
    case (bus.address)
      ADDR_ID:    read_mux = SYSTEM_ID;
      ADDR_TS:    read_mux = TIMESTAMP;
      ADDR_UP_LO: read_mux = cnt[31:0];
      ADDR_UP_HI: read_mux = shadow_hi;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (bus.address == ADDR_W'(SCR_BASE + i)) begin
            read_mux = scratch[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= bus.read;
      if (bus.read) begin
        rdata <= read_mux;
      end
    end
  end

  assign bus.readdata      = rdata;
  assign bus.readdatavalid = rvalid;

  // Clearing via a LO write has priority over the prescaled increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (clear_up) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) begin
        cnt <= cnt + 64'd1;
      end
    end
  end

  // The high word is captured with the pre-edge count so HI matches the last LO read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hi <= '0;
    end else if (snap_hi) begin
      shadow_hi <= cnt[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (wr_accept) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (bus.address == ADDR_W'(SCR_BASE + i)) begin
          for (int k = 0; k < 4; k++) begin
            if (bus.byteenable[k]) begin
              scratch[i][8*k +: 8] <= bus.writedata[8*k +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_regfile.sv
// Directed self-checking bench for sysid_regfile: one instance with PRESCALE=1 and
// one with PRESCALE=4, sharing clock and reset.
module tb_sysid_regfile;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   num_checks = 0;
  int   num_fails = 0;

  sysid_regfile_if #(.ADDR_W(4)) bus1 ();
  sysid_regfile_if #(.ADDR_W(4)) bus4 ();

  sysid_regfile #(
    .SYSTEM_ID(32'h52415801), .TIMESTAMP(32'h0), .PRESCALE(1),
    .NUM_SCRATCH(4), .ADDR_W(4)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1)
  );

  sysid_regfile #(
    .SYSTEM_ID(32'h52415801), .TIMESTAMP(32'h0), .PRESCALE(4),
    .NUM_SCRATCH(4), .ADDR_W(4)
  ) dut4 (
    .clock(clock), .reset_n(reset_n), .bus(bus4)
  );

  always #5 clock = ~clock;

  // Bus drivers: called on a falling edge, return on the falling edge after the transfer.
  task automatic bus1_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus1.address = a; bus1.writedata = d; bus1.byteenable = be; bus1.write = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus1.write = 1'b0;
  endtask

  task automatic bus1_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus1.address = a; bus1.read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus1.read = 1'b0;
    d = bus1.readdata;
    v = bus1.readdatavalid;
  endtask

  task automatic test_reset();
    bus1.address = '0; bus1.read = 1'b0; bus1.write = 1'b0;
    bus1.writedata = '0; bus1.byteenable = '0;
    bus4.address = '0; bus4.read = 1'b0; bus4.write = 1'b0;
    bus4.writedata = '0; bus4.byteenable = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    num_checks++;
    if (bus1.readdata !== 32'h0) begin
      num_fails++; $display("[TB] FAIL reset_readdata: got %h expected %h", bus1.readdata, 32'h0);
    end
    num_checks++;
    if (bus1.readdatavalid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL reset_valid: got %b expected %b", bus1.readdatavalid, 1'b0);
    end
    num_checks++;
    if (bus4.readdata !== 32'h0 || bus4.readdatavalid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL reset_dut4: got %h/%b expected 0/0", bus4.readdata, bus4.readdatavalid);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_id_regs();
    logic [31:0] d;
    logic        v;
    num_checks++;
    if (bus1.readdatavalid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL id_idle_valid: got %b expected 0", bus1.readdatavalid);
    end
    bus1_read(4'd0, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h52415801) begin
      num_fails++; $display("[TB] FAIL id_word0: got %h valid %b expected %h valid 1", d, v, 32'h52415801);
    end
    @(negedge clock);
    num_checks++;
    if (bus1.readdatavalid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL id_pulse_width: got valid %b expected 0", bus1.readdatavalid);
    end
    num_checks++;
    if (bus1.readdata !== 32'h52415801) begin
      num_fails++; $display("[TB] FAIL id_hold: got %h expected %h", bus1.readdata, 32'h52415801);
    end
    bus1_read(4'd1, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      num_fails++; $display("[TB] FAIL id_timestamp: got %h valid %b expected 0 valid 1", d, v);
    end
  endtask

  task automatic test_uptime_prescale();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    // 40 rising edges elapse, then the read is sampled at the 41st: floor(40/4)
    repeat (40) @(negedge clock);
    bus4.address = 4'd2; bus4.read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus4.read = 1'b0;
    num_checks++;
    if (bus4.readdatavalid !== 1'b1 || bus4.readdata !== 32'd10) begin
      num_fails++; $display("[TB] FAIL uptime_40: got %0d valid %b expected 10 valid 1", bus4.readdata, bus4.readdatavalid);
    end
    bus4.address = 4'd2; bus4.writedata = 32'h1234; bus4.byteenable = 4'b0000; bus4.write = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus4.write = 1'b0;
    repeat (8) @(negedge clock);
    bus4.address = 4'd2; bus4.read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus4.read = 1'b0;
    num_checks++;
    if (bus4.readdatavalid !== 1'b1 || bus4.readdata !== 32'd2) begin
      num_fails++; $display("[TB] FAIL uptime_clear: got %0d valid %b expected 2 valid 1", bus4.readdata, bus4.readdatavalid);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    logic        v;
    bus1_read(4'd3, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      num_fails++; $display("[TB] FAIL snap_before_lo: got %h expected 0", d);
    end
    // LO read sampled on the very edge where the low word carries into the high word
    force dut1.cnt = 64'h0000_0001_FFFF_FFFF;
    bus1.address = 4'd2; bus1.read = 1'b1;
    #1 release dut1.cnt;
    @(posedge clock);
    @(negedge clock);
    bus1.read = 1'b0;
    num_checks++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'hFFFF_FFFF) begin
      num_fails++; $display("[TB] FAIL snap_lo_carry: got %h expected %h", bus1.readdata, 32'hFFFF_FFFF);
    end
    repeat (5) @(negedge clock);
    bus1_read(4'd3, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h1) begin
      num_fails++; $display("[TB] FAIL snap_hi_coherent: got %h expected %h", d, 32'h1);
    end
    bus1_read(4'd2, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'd6) begin
      num_fails++; $display("[TB] FAIL snap_lo_after: got %0d expected 6", d);
    end
    bus1_read(4'd3, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h2) begin
      num_fails++; $display("[TB] FAIL snap_hi_updated: got %h expected %h", d, 32'h2);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic        v;
    bus1_write(4'd4, 32'hDEAD_BEEF, 4'b1111);
    bus1_write(4'd4, 32'h0000_0011, 4'b0001);
    bus1_read(4'd4, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'hDEAD_BE11) begin
      num_fails++; $display("[TB] FAIL scratch0_bytes: got %h expected %h", d, 32'hDEAD_BE11);
    end
    bus1_write(4'd7, 32'h1122_3344, 4'b1010);
    bus1_read(4'd7, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h1100_3300) begin
      num_fails++; $display("[TB] FAIL scratch3_lanes: got %h expected %h", d, 32'h1100_3300);
    end
    bus1_write(4'd8, 32'hCAFE_F00D, 4'b1111);
    bus1_read(4'd8, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      num_fails++; $display("[TB] FAIL unmapped_read: got %h valid %b expected 0 valid 1", d, v);
    end
    bus1_write(4'd0, 32'hFFFF_FFFF, 4'b1111);
    bus1_read(4'd0, d, v);
    num_checks++;
    if (d !== 32'h52415801) begin
      num_fails++; $display("[TB] FAIL id_readonly: got %h expected %h", d, 32'h52415801);
    end
    bus1_write(4'd3, 32'hFFFF_FFFF, 4'b1111);
    bus1_read(4'd3, d, v);
    num_checks++;
    if (d !== 32'h2) begin
      num_fails++; $display("[TB] FAIL hi_readonly: got %h expected %h", d, 32'h2);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic        v;
    bus1.address = 4'd5; bus1.writedata = 32'h5A5A_5A5A; bus1.byteenable = 4'b1111;
    bus1.read = 1'b1; bus1.write = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus1.read = 1'b0; bus1.write = 1'b0;
    num_checks++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'h0) begin
      num_fails++; $display("[TB] FAIL collide_read: got %h valid %b expected 0 valid 1", bus1.readdata, bus1.readdatavalid);
    end
    bus1_read(4'd5, d, v);
    num_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      num_fails++; $display("[TB] FAIL collide_dropped: got %h expected 0", d);
    end
  endtask

  task automatic test_back_to_back();
    bus1.address = 4'd0; bus1.read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    num_checks++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'h52415801) begin
      num_fails++; $display("[TB] FAIL b2b_first: got %h valid %b expected %h valid 1", bus1.readdata, bus1.readdatavalid, 32'h52415801);
    end
    bus1.address = 4'd4;
    @(posedge clock);
    @(negedge clock);
    num_checks++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'hDEAD_BE11) begin
      num_fails++; $display("[TB] FAIL b2b_second: got %h valid %b expected %h valid 1", bus1.readdata, bus1.readdatavalid, 32'hDEAD_BE11);
    end
    bus1.address = 4'd1;
    @(posedge clock);
    @(negedge clock);
    bus1.read = 1'b0;
    num_checks++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'h0) begin
      num_fails++; $display("[TB] FAIL b2b_third: got %h valid %b expected 0 valid 1", bus1.readdata, bus1.readdatavalid);
    end
    @(negedge clock);
    num_checks++;
    if (bus1.readdatavalid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL b2b_end: got valid %b expected 0", bus1.readdatavalid);
    end
  endtask

  task automatic test_reset_cancel();
    logic [31:0] d;
    logic        v;
    bus1.address = 4'd4; bus1.read = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus1.read = 1'b0;
    #1;
    num_checks++;
    if (bus1.readdatavalid !== 1'b0 || bus1.readdata !== 32'h0) begin
      num_fails++; $display("[TB] FAIL cancel_async: got %h valid %b expected 0 valid 0", bus1.readdata, bus1.readdatavalid);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      num_checks++;
      if (bus1.readdatavalid !== 1'b0 || bus1.readdata !== 32'h0) begin
        num_fails++; $display("[TB] FAIL cancel_after_%0d: got %h valid %b expected 0 valid 0", i, bus1.readdata, bus1.readdatavalid);
      end
    end
    for (int i = 4; i < 8; i++) begin
      bus1_read(4'(i), d, v);
      num_checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        num_fails++; $display("[TB] FAIL cancel_scratch_%0d: got %h valid %b expected 0 valid 1", i, d, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_uptime_prescale();
    test_snapshot();
    test_scratch();
    test_collision();
    test_back_to_back();
    test_reset_cancel();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/sysid_regfile.md
# sysid_regfile

Parametrised Avalon-MM system-identification slave for the Nios II system. It supersedes the fixed two-word ID/timestamp slave by adding:
- a registered read path with `readdatavalid`;
- a free-running 64-bit uptime counter with a configurable prescaler and a coherent high-word snapshot;
- a configurable bank of byte-writable scratch registers.

Software uses it to identify the build, measure elapsed time and pass boot state across soft resets.

## Interface
Parameters:
- `SYSTEM_ID`, default 32'h52415801: value returned at word 0.
- `TIMESTAMP`, default 32'h0: build timestamp returned at word 1.
- `PRESCALE`, default 1: clocks per uptime increment. Legal range 1..65535.
- `NUM_SCRATCH`, default 4: number of scratch registers. Legal range 1..8.
- `ADDR_W`, default 4: word-address width. Must satisfy 2^ADDR_W ≥ 4+NUM_SCRATCH.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  word address.
- `read`  in  1  read strobe, one cycle per transfer.
- `write`  in  1  write strobe, one cycle per transfer.
- `writedata`  in  32  write data.
- `byteenable`  in  4  byte lanes for writes.
- `readdata`  out  32  read data, valid when `readdatavalid`=1.
- `readdatavalid`  out  1  one-cycle pulse, one per accepted read.

## Operation
Register map (word address):
- 0 SYSTEM_ID: read-only.
- 1 TIMESTAMP: read-only.
- 2 UPTIME_LO:
  - Read returns `cnt[31:0]` and, on the same edge, loads `shadow_hi <= cnt[63:32]`.
  - Write of any data, any byteenable, clears `cnt` and the prescaler.
- 3 UPTIME_HI: read returns `shadow_hi`. The counter itself is never read directly. Writes are ignored.
- 4 .. 3+NUM_SCRATCH, SCRATCH[i]: read/write. Each byte lane k is written only when `byteenable[k]`=1.
- Any other address: reads return 0; writes are ignored.

Uptime counter:
- Prescaler `pre` counts 0..PRESCALE-1, then wraps to 0.
- `cnt` increments by 1 on each cycle where `pre`=PRESCALE-1. With PRESCALE=1 it increments every clock.
- `cnt` wraps from 2^64-1 to 0 with no flag.
- A clear write takes priority over an increment in the same cycle.

Reads:
- `read` and `write` asserted together: the read is serviced, the write is dropped.
- No waitrequest; every strobe is accepted.

Reset (`reset_n`=0), applied asynchronously and held while low:
- `readdata`=0, `readdatavalid`=0.
- `cnt`=0, `pre`=0, `shadow_hi`=0.
- All SCRATCH=0.
- Reset during an outstanding read cancels it: no `readdatavalid` is produced after release.

## Timing
- Read latency is fixed at 1. `read` sampled at edge N gives `readdatavalid`=1 and `readdata` during cycle N+1.
- Back-to-back reads on consecutive cycles yield consecutive valid pulses.
- `readdata` holds its last value while `readdatavalid`=0.
- Read data is the register value before edge N. A write to the same scratch register at edge N-1 is therefore visible.
- Snapshot read of UPTIME_HI:
  - Reading HI at any cycle after a LO read returns the high word coherent with that LO value.
  - Reading HI before any LO read since reset returns 0.
- Clear write at edge N: `cnt`=0 and `pre`=0 after edge N. The first increment follows PRESCALE edges later.
- Scratch write at edge N is visible to a read sampled at edge N+1.

## Test plan
- Reset, then read addresses 0 and 1 with defaults → `readdata`=32'h52415801, then 32'h0. Each `readdatavalid` pulse is exactly 1 cycle, 1 cycle after `read`.
- PRESCALE=4, release reset, wait 40 clocks, read UPTIME_LO → value = floor(elapsed/4) ±0. A subsequent write to address 2 followed by a read 8 clocks later → 2.
- Force `cnt`=64'h0000_0001_FFFF_FFFF (PRESCALE=1), read LO at the edge where the carry occurs, wait 5 clocks, read HI → LO=32'hFFFFFFFF, HI=1, not 2.
- SCRATCH[0]: write 32'hDEADBEEF with byteenable 4'b1111, then write 32'h00000011 with byteenable 4'b0001 → read returns 32'hDEADBE11. Read of address 4+NUM_SCRATCH → 0.
- `read` and `write` to SCRATCH[1] in the same cycle with data 32'h5A5A5A5A → read returns 0, SCRATCH[1] remains 0.
- Assert `reset_n` low for 1 cycle immediately after a read strobe → no `readdatavalid`. After release, `readdata`=0 and all scratch registers read 0.
